synth_cfg_loader: RTL
=====================

Name: synth_cfg_loader

Overview:
Byte-stream frame receiver that builds the MCU-to-FPGA synth configuration (synth_t from protocol_pkg) from framed, checksummed writes.
- Writes land in a shadow copy; an explicit COMMIT frame copies the shadow to the active copy atomically, so oscillators and effects never see a half-written configuration.
- Sits between the SPI/UART byte deserialiser and the oscillator bank, reverb, pan and master-volume stages.

Parameters:
N_OSC, `N_OSCILLATORS, number of wavegen records; an elaboration assertion requires it to equal the package macro.
ENV_LEN, `ENVELOPE_LEN, envelope stages per wavegen; an elaboration assertion requires it to equal the package macro.
TIMEOUT, 4096, maximum clk cycles between bytes inside a frame before the frame is aborted.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid && rx_ready
synth_o  out  synth_t  active configuration
commit_o  out  1  one-cycle pulse when the active configuration is updated
ok_o  out  1  one-cycle pulse on every good frame
err_o  out  1  one-cycle pulse on every rejected frame
err_code  out  2  reason for the last error (held): 0 checksum, 1 bad index, 2 bad opcode, 3 timeout
busy_o  out  1  high while a frame is in progress

Behaviour:
- Reset (async, rstn low):
  - Active and shadow copies are cleared per the reset_synth_t rules: all fields 0, every shape = SIN.
  - commit_o, ok_o, err_o, busy_o = 0; err_code = 0; rx_ready = 1; FSM goes to IDLE.
  - Reset mid-frame discards the frame with no pulses.
- Frame format: OP, IDX, payload, CHK.
  - CHK = XOR of all preceding bytes of the frame.
  - Payload is MSB-first in packed-struct bit order.
- Opcodes and payload sizes:
  - 0x01 WG: WG_BYTES = 10 + 2*ENV_LEN (26 at default) bytes of wavegen_t.
  - 0x02 GLB: GLB_BYTES = 60 bytes; master_volume, then reverb (tau[0..5], then gain[0..6]), then pan.
  - 0x03 COMMIT and 0x04 CLEAR: 0 payload bytes; IDX is present but ignored.
- FSM: IDLE -> IDX -> PAYLOAD (byte counter) -> CHK -> APPLY -> IDLE.
- OP byte handling:
  - Any opcode other than 0x01-0x04 is handled entirely in IDLE: err_o pulses, err_code = 2, FSM stays in IDLE. This is the resync rule.
  - A valid opcode moves the FSM to IDX.
- Payload is shifted into a staging register of max(WG_BYTES, GLB_BYTES) bytes. The shadow copy is never touched before the checksum passes.
- APPLY state (1 cycle, rx_ready = 0), entered from CHK:
  - Checksum mismatch: discard, err_o pulses, err_code = 0.
  - WG with IDX >= N_OSC: discard, err_o pulses, err_code = 1.
  - Otherwise, for a WG or GLB frame, the staged data is written to the shadow copy.
  - COMMIT: active <= shadow, and commit_o pulses in the same cycle as ok_o.
  - CLEAR: shadow <= reset values; the active copy is unchanged.
  - Every accepted frame pulses ok_o.
- Latency: ok_o, commit_o and err_o are registered and assert 2 cycles after the CHK handshake. synth_o changes on the same edge that commit_o rises.
- rx_ready = 1 in every state except APPLY.
- Timeout:
  - The idle counter resets on every accepted byte.
  - When it reaches TIMEOUT while not in IDLE: abort, err_o pulses, err_code = 3, FSM returns to IDLE.
  - In IDLE the counter is frozen.
- busy_o = (state != IDLE).
- Back-to-back frames need no gap beyond the single APPLY cycle.

Decomposition:
- Add to protocol_pkg:
  - opcode enum cfg_op_t (WG, GLB, COMMIT, CLEAR);
  - err_code enum cfg_err_t;
  - WG_BYTES and GLB_BYTES localparams derived from ENVELOPE_LEN.
- reset_synth_t is reused from protocol_pkg for reset and CLEAR.
- One sub-module, cfg_frame_rx: OP/IDX/payload/CHK parsing, XOR accumulation, timeout counter. It emits a staged record plus a good/bad strobe.
- The top level owns the shadow and active copies and the APPLY/commit logic.

Test Plan:
- Reset, then read outputs -> every synth_o.wave_gens[i].shape = SIN, every other field 0, rx_ready = 1, no pulses.
- WG frame, IDX = 3, freq = 0x00010000, correct CHK, then COMMIT frame -> synth_o unchanged after the WG frame. Two cycles after the COMMIT's CHK, commit_o and ok_o pulse and wave_gens[3].freq = 0x00010000.
- GLB frame with one bit of CHK flipped, then COMMIT -> err_o pulses with err_code = 0; shadow and active copies are unchanged (master_volume stays 0).
- WG frame with IDX = N_OSC and correct CHK -> err_o pulses with err_code = 1 and no state changes. A following valid frame is accepted (ok_o pulses).
- Byte 0x7F in IDLE -> err_o pulses with err_code = 2. Then a WG frame, stall TIMEOUT cycles after its 5th byte -> err_o pulses with err_code = 3 and busy_o drops.
- Commit a WG write, send CLEAR, then COMMIT -> active copy unchanged after CLEAR; after the COMMIT the written wavegen returns to freq = 0, shape = SIN.

Source files
------------

// File: rtl/protocol_pkg.sv
// MCU-to-FPGA synth configuration types and config-frame protocol.
// Shared by the loader, oscillator bank and effect stages.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 8
`endif

package protocol_pkg;

  localparam int N_OSCILLATORS = `N_OSCILLATORS;
  localparam int ENVELOPE_LEN  = `ENVELOPE_LEN;

  typedef enum logic [7:0] {
    SAW = 8'd0,
    SIN = 8'd1,
    SQR = 8'd2,
    TRI = 8'd3
  } shape_t;

  typedef struct packed {
    logic [31:0]                        freq;
    logic [15:0]                        amp;
    logic [15:0]                        phase;
    shape_t                             shape;
    logic [7:0]                         detune;
    logic [0:ENVELOPE_LEN-1][15:0]      env;
  } wavegen_t;

  typedef struct packed {
    logic [0:5][31:0] tau;
    logic [0:6][31:0] gain;
  } reverb_t;

  typedef struct packed {
    wavegen_t [0:N_OSCILLATORS-1] wave_gens;
    logic [31:0]                  master_volume;
    reverb_t                      reverb;
    logic [31:0]                  pan;
  } synth_t;

  typedef enum logic [7:0] {
    WG     = 8'h01,
    GLB    = 8'h02,
    COMMIT = 8'h03,
    CLEAR  = 8'h04
  } cfg_op_t;

  typedef enum logic [1:0] {
    ERR_CHK = 2'd0,
    ERR_IDX = 2'd1,
    ERR_OP  = 2'd2,
    ERR_TMO = 2'd3
  } cfg_err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_PAYLOAD,
    S_CHK,
    S_APPLY
  } cfg_state_t;

  localparam int WG_BYTES  = 10 + 2 * ENVELOPE_LEN;
  localparam int GLB_BYTES = 60;
  localparam int STG_BYTES =
    (WG_BYTES > GLB_BYTES) ? WG_BYTES : GLB_BYTES;

  function automatic synth_t reset_synth_t();
    synth_t s;
    s = '0;
    for (int i = 0; i < N_OSCILLATORS; i++)
      s.wave_gens[i].shape = SIN;
    return s;
  endfunction

endpackage

// File: rtl/synth_cfg_loader_rx.sv
// Config frame parser: OP/IDX/payload/CHK, XOR check, byte timeout.
// Emits the staged record with a one-cycle good or bad verdict.
module cfg_frame_rx
  import protocol_pkg::*;
#(
  parameter int N_OSC   = N_OSCILLATORS,
  parameter int TIMEOUT = 4096,
  parameter int IW      = $clog2(N_OSC)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   o_good,
  output logic                   o_bad,
  output cfg_err_t               o_code,
  output cfg_op_t                o_op,
  output logic [IW-1:0]          o_idx,
  output logic [STG_BYTES*8-1:0] o_stage,
  output logic                   o_busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(STG_BYTES);
  localparam int SB = STG_BYTES * 8;

  cfg_state_t       r_state;
  cfg_state_t       w_next;
  cfg_op_t          r_op;
  logic [7:0]       r_idx;
  logic [7:0]       r_xor;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_last;
  logic [TW-1:0]    r_tmo;
  logic             r_chk_ok;
  logic [SB-1:0]    r_stage;
  logic             w_acc;
  logic             w_op_ok;
  logic             w_tmo;
  logic             w_idx_bad;

  assign rx_ready  = (r_state != S_APPLY);
  assign o_busy    = (r_state != S_IDLE);
  assign w_acc     = rx_valid && rx_ready;
  assign w_op_ok   = rx_data inside {8'h01, 8'h02, 8'h03, 8'h04};
  assign w_idx_bad = (r_op == WG) && (r_idx >= 8'(N_OSC));
  assign w_tmo     = (r_state inside {S_IDX, S_PAYLOAD, S_CHK})
                  && !w_acc && (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_last = '0;
    unique case (1'b1)
      r_op == WG:  w_last = CW'(WG_BYTES - 1);
      r_op == GLB: w_last = CW'(GLB_BYTES - 1);
      default:     w_last = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_acc && w_op_ok) w_next = S_IDX;
      S_IDX:     if (w_acc)
                   w_next = (r_op inside {WG, GLB}) ? S_PAYLOAD : S_CHK;
      S_PAYLOAD: if (w_acc && r_cnt == w_last) w_next = S_CHK;
      S_CHK:     if (w_acc) w_next = S_APPLY;
      S_APPLY:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_IDLE;
  end

  always_comb begin
    o_good = 1'b0;
    o_bad  = 1'b0;
    o_code = ERR_CHK;
    priority case (1'b1)
      w_tmo: begin
        o_bad  = 1'b1;
        o_code = ERR_TMO;
      end
      (r_state == S_IDLE) && w_acc && !w_op_ok: begin
        o_bad  = 1'b1;
        o_code = ERR_OP;
      end
      (r_state == S_APPLY) && !r_chk_ok: begin
        o_bad  = 1'b1;
        o_code = ERR_CHK;
      end
      (r_state == S_APPLY) && w_idx_bad: begin
        o_bad  = 1'b1;
        o_code = ERR_IDX;
      end
      r_state == S_APPLY: o_good = 1'b1;
      default: ;
    endcase
  end

  // Idle counter: cleared by any byte, frozen while no frame is open
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo    <= '0;
      r_op     <= CLEAR;
      r_idx    <= '0;
      r_xor    <= '0;
      r_cnt    <= '0;
      r_chk_ok <= 1'b0;
      r_stage  <= '0;
    end else begin
      if (w_acc)
        r_tmo <= '0;
      else if (r_state != S_IDLE && r_tmo != TW'(TIMEOUT))
        r_tmo <= r_tmo + 1'b1;
      if (w_acc) begin
        case (r_state)
          S_IDLE: if (w_op_ok) begin
            r_op  <= cfg_op_t'(rx_data);
            r_xor <= rx_data;
          end
          S_IDX: begin
            r_idx <= rx_data;
            r_xor <= r_xor ^ rx_data;
            r_cnt <= '0;
          end
          S_PAYLOAD: begin
            r_stage <= {r_stage[SB-9:0], rx_data};
            r_xor   <= r_xor ^ rx_data;
            r_cnt   <= r_cnt + 1'b1;
          end
          S_CHK: r_chk_ok <= (rx_data == r_xor);
          default: ;
        endcase
      end
    end
  end

  assign o_op    = r_op;
  assign o_idx   = r_idx[IW-1:0];
  assign o_stage = r_stage;

endmodule

// File: rtl/synth_cfg_loader.sv
// Synth configuration loader: shadow/active copies, atomic commit.
// Frames are parsed by cfg_frame_rx; this level applies verdicts.
module synth_cfg_loader
  import protocol_pkg::*;
#(
  parameter int N_OSC   = `N_OSCILLATORS,
  parameter int ENV_LEN = `ENVELOPE_LEN,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output synth_t     synth_o,
  output logic       commit_o,
  output logic       ok_o,
  output logic       err_o,
  output logic [1:0] err_code,
  output logic       busy_o
);

  localparam int IW = $clog2(N_OSC);

  if (N_OSC != `N_OSCILLATORS) begin : g_bad_nosc
    $error("N_OSC must equal N_OSCILLATORS");
  end
  if (ENV_LEN != `ENVELOPE_LEN) begin : g_bad_env
    $error("ENV_LEN must equal ENVELOPE_LEN");
  end

  synth_t                 r_shadow;
  synth_t                 r_active;
  logic                   r_commit;
  logic                   r_ok;
  logic                   r_err;
  cfg_err_t               r_err_code;
  logic                   w_good;
  logic                   w_bad;
  cfg_err_t               w_code;
  cfg_op_t                w_op;
  logic [IW-1:0]          w_idx;
  logic [STG_BYTES*8-1:0] w_stage;

  cfg_frame_rx #(
    .N_OSC   (N_OSC),
    .TIMEOUT (TIMEOUT),
    .IW      (IW)
  ) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .o_good   (w_good),
    .o_bad    (w_bad),
    .o_code   (w_code),
    .o_op     (w_op),
    .o_idx    (w_idx),
    .o_stage  (w_stage),
    .o_busy   (busy_o)
  );

  // Shadow only moves on a verified frame; active only on COMMIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow   <= reset_synth_t();
      r_active   <= reset_synth_t();
      r_commit   <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_CHK;
    end else begin
      r_commit <= 1'b0;
      r_ok     <= w_good;
      r_err    <= w_bad;
      if (w_bad) r_err_code <= w_code;
      if (w_good) begin
        unique case (1'b1)
          w_op == WG:
            r_shadow.wave_gens[w_idx] <= w_stage[WG_BYTES*8-1:0];
          w_op == GLB:
            {r_shadow.master_volume, r_shadow.reverb, r_shadow.pan}
              <= w_stage[GLB_BYTES*8-1:0];
          w_op == COMMIT: begin
            r_active <= r_shadow;
            r_commit <= 1'b1;
          end
          default: r_shadow <= reset_synth_t();
        endcase
      end
    end
  end

  assign synth_o  = r_active;
  assign commit_o = r_commit;
  assign ok_o     = r_ok;
  assign err_o    = r_err;
  assign err_code = r_err_code;

endmodule
